// File: rtl/fetch_r32i_pkg.sv
// Shared types for the RV32I fetch stage: FSM states and buffered entry layout.
package fetchPkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_GNT  = 2'd1,
      WAIT_DATA = 2'd2,
      DROP      = 2'd3
   } state_t;

   // One buffered instruction: fetch address paired with the returned word.
   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] instr;
   } entry_t;

endpackage

// File: rtl/fetch_r32i_if.sv
// Instruction memory request/grant/response bus.
interface fetch_r32i_if #(parameter int dataW = 32);
   logic             MemReq;
   logic [dataW-1:0] MemAddr;
   logic             MemGnt;
   logic             MemRValid;
   logic [dataW-1:0] MemRData;

   // Fetch stage side: drives the request, receives grant and read data.
   modport master (output MemReq, MemAddr, input MemGnt, MemRValid, MemRData);
   // Memory side.
   modport slave  (input MemReq, MemAddr, output MemGnt, MemRValid, MemRData);
endinterface

// File: rtl/fetch_r32i_fifo.sv
// Small synchronous FIFO with flush; power-of-two depth, pointers wrap naturally.
module fetchFifoR32I #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_data,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [W-1:0]               o_data,
   output logic                       o_valid,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [PW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign w_push  = i_push & (r_cnt != L_FULL);
   assign w_pop   = i_pop  & (r_cnt != '0);
   assign o_data  = r_mem[r_rd];
   assign o_valid = (r_cnt != '0);
   assign o_count = r_cnt;

   // Storage, pointers and occupancy; flush discards everything including a same-cycle push.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

// File: rtl/fetch_r32i.sv
// RV32I instruction fetch: single-outstanding memory reads into a small buffer feeding decode.
module fetch_r32i
   import fetchPkg::*;
#(
   parameter int dataW = DATA_W,   // must match DATA_W of the entry layout
   parameter int depth = 2
) (
   input  logic              i_clock,
   input  logic              i_nReset,
   input  logic [dataW-1:0]  i_FetchAddr,
   output logic              o_AddrTaken,
   input  logic              i_Flush,
   fetch_r32i_if.master      mem,
   output logic              o_InstrValid,
   input  logic              i_InstrReady,
   output logic [dataW-1:0]  o_Instr,
   output logic [dataW-1:0]  o_InstrAddr,
   output logic              o_Misaligned
);
   localparam int CW = $clog2(depth);
   localparam logic [CW+1:0] L_DEPTH = (CW+2)'(depth);

   state_t           r_state;
   state_t           w_next;
   logic [dataW-1:0] r_addr;
   logic             r_misaligned;

   logic             w_req;
   logic [dataW-1:0] w_addr;
   logic             w_latch;
   logic             w_push;
   logic             w_space;
   logic [CW:0]      w_count;
   logic [CW+1:0]    w_used;
   entry_t           w_push_entry;
   entry_t           w_head;

   // Buffer space counts the in-flight response so the FIFO can never overflow.
   assign w_used  = {1'b0, w_count} + {{(CW+1){1'b0}}, (r_state == WAIT_DATA)};
   assign w_space = (w_used < L_DEPTH);

   // Next state and request generation; request is held off while reset is asserted.
   always_comb begin
      w_next  = r_state;
      w_req   = 1'b0;
      w_addr  = r_addr;
      w_latch = 1'b0;
      w_push  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_space && !i_Flush && i_nReset) begin
               w_req   = 1'b1;
               w_addr  = i_FetchAddr;
               w_latch = 1'b1;
               w_next  = mem.MemGnt ? WAIT_DATA : WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            w_req = 1'b1;
            if (mem.MemGnt)   w_next = i_Flush ? DROP : WAIT_DATA;
            else if (i_Flush) w_next = IDLE;
         end
         WAIT_DATA: begin
            if (mem.MemRValid) begin
               w_push = 1'b1;
               w_next = IDLE;
            end else if (i_Flush) begin
               w_next = DROP;
            end
         end
         DROP: begin
            if (mem.MemRValid) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign mem.MemReq  = w_req;
   assign mem.MemAddr = w_addr;
   assign o_AddrTaken = w_req & mem.MemGnt & ~i_Flush;

   // State, latched request address and sticky misalignment flag.
   always_ff @(posedge i_clock or negedge i_nReset) begin
      if (!i_nReset) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_addr <= i_FetchAddr;
            if (i_FetchAddr[1:0] != 2'b00) r_misaligned <= 1'b1;
         end
      end
   end

   assign w_push_entry.addr  = r_addr;
   assign w_push_entry.instr = mem.MemRData;

   fetchFifoR32I #(
      .DEPTH (depth),
      .W     ($bits(entry_t))
   ) u_fifo (
      .i_clk   (i_clock),
      .i_rst_n (i_nReset),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (o_InstrValid & i_InstrReady),
      .i_flush (i_Flush),
      .o_data  (w_head),
      .o_valid (o_InstrValid),
      .o_count (w_count)
   );

   assign o_Instr      = w_head.instr;
   assign o_InstrAddr  = w_head.addr;
   assign o_Misaligned = r_misaligned;
endmodule

// File: tb/tb_fetch_r32i.sv
// Directed bench for fetch_r32i with hand-computed expectations.
module tb_fetch_r32i;
   logic        clk;
   logic        nReset;
   logic [31:0] fa;
   logic        taken;
   logic        flush;
   logic        ivalid;
   logic        irdy;
   logic [31:0] instr;
   logic [31:0] iaddr;
   logic        mis;
   int          total;
   int          bad;

   fetch_r32i_if #(.dataW(32)) mif ();

   fetch_r32i #(.dataW(32), .depth(2)) dut (
      .i_clock      (clk),
      .i_nReset     (nReset),
      .i_FetchAddr  (fa),
      .o_AddrTaken  (taken),
      .i_Flush      (flush),
      .mem          (mif),
      .o_InstrValid (ivalid),
      .i_InstrReady (irdy),
      .o_Instr      (instr),
      .o_InstrAddr  (iaddr),
      .o_Misaligned (mis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nReset        = 1'b0;
      fa            = '0;
      flush         = 1'b0;
      irdy          = 1'b0;
      mif.MemGnt    = 1'b0;
      mif.MemRValid = 1'b0;
      mif.MemRData  = '0;
      tick();
      nReset = 1'b1;
   endtask

   // Zero-wait fetch from IDLE: grant with request, data the next cycle.
   task automatic mem_fetch(input logic [31:0] a, input logic [31:0] d);
      fa         = a;
      mif.MemGnt = 1'b1;
      #1;
      chk("zw_req",   mif.MemReq, 1);
      chk("zw_taken", taken, 1);
      chk("zw_addr",  mif.MemAddr, a);
      tick();
      mif.MemGnt    = 1'b0;
      mif.MemRValid = 1'b1;
      mif.MemRData  = d;
      #1;
      chk("zw_noreq", mif.MemReq, 0);
      tick();
      mif.MemRValid = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      nReset = 1'b0; fa = '0; flush = 1'b0; irdy = 1'b0;
      mif.MemGnt = 1'b0; mif.MemRValid = 1'b0; mif.MemRData = '0;
      #12;
      // reset values
      chk("rst_req",   mif.MemReq, 0);
      chk("rst_maddr", mif.MemAddr, 0);
      chk("rst_taken", taken, 0);
      chk("rst_ivld",  ivalid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_iaddr", iaddr, 0);
      chk("rst_mis",   mis, 0);
      nReset = 1'b1;
      tick();

      // first zero-wait fetch
      mem_fetch(32'h0, 32'h00000013);
      #1;
      chk("t1_ivld",  ivalid, 1);
      chk("t1_instr", instr, 32'h00000013);
      chk("t1_iaddr", iaddr, 32'h0);

      // second fetch fills the buffer; no further request until a pop
      mem_fetch(32'h4, 32'h00400093);
      fa = 32'h8;
      #1;
      chk("t2_full_noreq", mif.MemReq, 0);
      chk("t2_head0", iaddr, 32'h0);
      tick();
      chk("t2_still_noreq", mif.MemReq, 0);
      chk("t2_ivld", ivalid, 1);
      irdy = 1'b1;
      tick();
      irdy = 1'b0;
      #1;
      chk("t2_head1_addr",  iaddr, 32'h4);
      chk("t2_head1_instr", instr, 32'h00400093);
      chk("t2_req_after_pop", mif.MemReq, 1);
      chk("t2_req_addr", mif.MemAddr, 32'h8);

      // grant delayed three cycles: request and address held
      do_reset();
      fa = 32'h100;
      #1;
      chk("t3_req0",   mif.MemReq, 1);
      chk("t3_addr0",  mif.MemAddr, 32'h100);
      chk("t3_taken0", taken, 0);
      tick();
      fa = 32'h200;
      #1;
      chk("t3_req1",   mif.MemReq, 1);
      chk("t3_addr1",  mif.MemAddr, 32'h100);
      chk("t3_taken1", taken, 0);
      tick();
      chk("t3_addr2",  mif.MemAddr, 32'h100);
      tick();
      mif.MemGnt = 1'b1;
      #1;
      chk("t3_taken_gnt", taken, 1);
      chk("t3_addr_gnt",  mif.MemAddr, 32'h100);
      tick();
      mif.MemGnt = 1'b0;
      #1;
      chk("t3_taken_after", taken, 0);
      chk("t3_req_after",   mif.MemReq, 0);
      mif.MemRValid = 1'b1;
      mif.MemRData  = 32'hAAAA5555;
      tick();
      mif.MemRValid = 1'b0;
      #1;
      chk("t3_iaddr", iaddr, 32'h100);
      chk("t3_instr", instr, 32'hAAAA5555);

      // flush in WAIT_DATA with one entry buffered; late response discarded
      do_reset();
      mem_fetch(32'h40, 32'h11111111);
      fa = 32'h300;
      mif.MemGnt = 1'b1;
      tick();
      mif.MemGnt = 1'b0;
      flush = 1'b1;
      #1;
      chk("t4_req_wd", mif.MemReq, 0);
      chk("t4_taken",  taken, 0);
      tick();
      flush = 1'b0;
      fa = 32'h200;
      #1;
      chk("t4_empty", ivalid, 0);
      chk("t4_drop_noreq", mif.MemReq, 0);
      tick();
      mif.MemRValid = 1'b1;
      mif.MemRData  = 32'hDEADBEEF;
      #1;
      chk("t4_drop_noreq2", mif.MemReq, 0);
      tick();
      mif.MemRValid = 1'b0;
      #1;
      chk("t4_discard", ivalid, 0);
      chk("t4_newreq",  mif.MemReq, 1);
      chk("t4_newaddr", mif.MemAddr, 32'h200);

      // flush with same-cycle grant from WAIT_GNT
      do_reset();
      fa = 32'h500;
      tick();
      mif.MemGnt = 1'b1;
      flush = 1'b1;
      #1;
      chk("t5_req",   mif.MemReq, 1);
      chk("t5_taken", taken, 0);
      tick();
      mif.MemGnt = 1'b0;
      flush = 1'b0;
      #1;
      chk("t5_drop_noreq", mif.MemReq, 0);
      mif.MemRValid = 1'b1;
      mif.MemRData  = 32'h55555555;
      tick();
      mif.MemRValid = 1'b0;
      #1;
      chk("t5_discard", ivalid, 0);
      chk("t5_idle_req", mif.MemReq, 1);

      // misaligned request, then reset mid-WAIT_DATA
      do_reset();
      fa = 32'h102;
      mif.MemGnt = 1'b1;
      #1;
      chk("t6_full_addr", mif.MemAddr, 32'h102);
      chk("t6_mis_pre", mis, 0);
      tick();
      mif.MemGnt = 1'b0;
      fa = 32'h0;
      #1;
      chk("t6_mis_set", mis, 1);
      tick();
      tick();
      chk("t6_mis_sticky", mis, 1);
      nReset = 1'b0;
      #1;
      chk("t6_rst_req",   mif.MemReq, 0);
      chk("t6_rst_maddr", mif.MemAddr, 0);
      chk("t6_rst_mis",   mis, 0);
      chk("t6_rst_ivld",  ivalid, 0);
      chk("t6_rst_iaddr", iaddr, 0);
      #2;
      nReset = 1'b1;
      mif.MemRValid = 1'b1;
      mif.MemRData  = 32'h77777777;
      tick();
      mif.MemRValid = 1'b0;
      #1;
      chk("t6_stale_ignored", ivalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound so the run always ends.
   initial begin
      #20000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
